qoi_dec: RTL
============

QOI_DEC -- requirements
Module: qoi_dec

Interface
REQ-001 SHALL have ports: clk input 1, the single clock; all logic is on its rising edge.
REQ-002 SHALL have port rst input 1; reset is synchronous and active-high.
REQ-003 SHALL have ports: cs input 1 (chip select); we input 1 (1=write, 0=read); addr input addr_t (3-bit register index).
REQ-004 SHALL have ports: data_i input byte_t (write data); data_o output byte_t (combinational read mux of addr).
REQ-005 SHALL map write registers: 0=encoded byte in; 3=control (bit7 start); 4..7=pixel total, little-endian, 30 bits with reg7[5:0].
REQ-006 SHALL map read registers: 0=decoded byte out; 3=status; 4..7=pixels emitted, little-endian, 30 bits; others read 0.
REQ-007 SHALL set status bits: [7]=working, [6:4]=0, [3:2]=byte index of current output pixel, [1]=need_input, [0]=out_valid.

Function
REQ-008 SHALL define a write strobe as cs&we&addr==0 and a read strobe as cs&~we&addr==0, each consuming exactly one byte per cycle asserted.
REQ-009 SHALL use states IDLE, OPCODE, OPERAND, EMIT, DONE.
REQ-010 IDLE/DONE: a write to reg3 with bit7=1 SHALL latch the total, clear the emitted count, set prev_px={r0,g0,b0,a255}, zero all 64 index entries, and go to OPCODE next cycle; a total of 0 SHALL go straight to DONE.
REQ-011 Start writes while in OPCODE/OPERAND/EMIT SHALL be ignored.
REQ-012 OPCODE: need_input=1; on a write strobe, classify the byte: 0xFE RGB (3 operands), 0xFF RGBA (4 operands), tag 00 INDEX, 01 DIFF, 10 LUMA (1 operand), 11 RUN.
REQ-013 INDEX/DIFF/RUN SHALL go to EMIT; operand ops SHALL go to OPERAND.
REQ-014 OPERAND: need_input=1; each write strobe stores one operand; after the last operand, go to EMIT.
REQ-015 Pixel formation SHALL use mod-256 arithmetic:
 - RGB: prev alpha kept.
 - DIFF: dr,dg,db = 2-bit fields minus 2.
 - LUMA: dg = byte0[5:0]-32; dr = dg+hi nibble-8; db = dg+lo nibble-8.
 - INDEX: pixel = index_arr[byte[5:0]].
 - RUN: pixel = prev_px repeated byte[5:0]+1 times (1..62).
REQ-016 On entering EMIT, the pixel SHALL be written to index_arr[(r*3+g*5+b*7+a*11)%64] and to prev_px.
REQ-017 EMIT: out_valid=1; reg0 SHALL present r,g,b,a for byte index 0..3; each read strobe advances the index.
REQ-018 The read strobe on byte index 3 SHALL increment the emitted count and reset the index to 0.
 - Then: DONE if the count equals the total; else the next run pixel stays in EMIT; else go to OPCODE.
REQ-019 A run that would exceed the total SHALL be truncated at the total.
REQ-020 Write strobes outside OPCODE/OPERAND SHALL be ignored, and read strobes outside EMIT SHALL have no side effect.
REQ-021 working SHALL be 1 in OPCODE, OPERAND and EMIT.
REQ-022 The first pixel byte SHALL be readable in the cycle after the completing write strobe (one-cycle latency).

Reset
REQ-023 rst SHALL force IDLE, with status=0x00, count=0, byte index=0, prev_px={0,0,0,255} and the index array zeroed.
REQ-024 Assertion in any state, including mid-pixel or mid-run, SHALL abandon the operation with no further output.
REQ-025 The write register file SHALL reset to 0.

Structure
REQ-026 byte_t, addr_t, pixel_t, index_t and size_t SHALL live in package qoi_types, together with the opcode constants 0xFE/0xFF and the 2-bit tag constants.
REQ-027 The hash SHALL be a sub-module qoi_hash (pixel_t in, index_t out), reusable by the encoder.

Verification
REQ-028 total=1; start; write FF 10 20 30 40 -> reg0 reads 10,20,30,40; status then 0x00; count=1.
REQ-029 total=3; start; write FE 64 C8 32, then C1 -> reads 64,C8,32,FF twice more; DONE after the 12th read.
REQ-030 total=1; start; write 6A (DIFF: dr=0, dg=0, db=0) -> reads 00,00,00,FF.
REQ-031 total=2; write FE 0A 0B 0C, then the INDEX byte for hash(0A,0B,0C,FF) -> the second pixel equals the first; LUMA byte 0xA0 + 0x88 from prev 0,0,0 -> pixel 00,00,00 unchanged.
REQ-032 total=2; write C9 (run 10) -> only 2 pixels emitted, then DONE; later writes ignored.
REQ-033 Assert rst after 2 of 4 pixel bytes are read -> status 0x00, count 0, a read of reg0 has no effect.

Source files
------------

// File: rtl/qoi_types.sv
// Shared types, opcode constants and helpers for the QOI codec.
// Used by the decoder top and the reusable hash unit.
package qoi_types;

    typedef logic [7:0]  byte_t;
    typedef logic [2:0]  addr_t;
    typedef logic [5:0]  index_t;
    typedef logic [29:0] size_t;

    typedef struct packed {
        byte_t r;
        byte_t g;
        byte_t b;
        byte_t a;
    } pixel_t;

    localparam byte_t OP_RGB  = 8'hFE;
    localparam byte_t OP_RGBA = 8'hFF;

    localparam logic [1:0] TAG_INDEX = 2'b00;
    localparam logic [1:0] TAG_DIFF  = 2'b01;
    localparam logic [1:0] TAG_LUMA  = 2'b10;
    localparam logic [1:0] TAG_RUN   = 2'b11;

    localparam pixel_t PX_INIT = '{
        r: 8'h00, g: 8'h00, b: 8'h00, a: 8'hFF
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_OPERAND,
        S_EMIT,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        K_RGB,
        K_RGBA,
        K_INDEX,
        K_DIFF,
        K_LUMA,
        K_RUN
    } kind_t;

    // Full-byte opcodes take priority over the 2-bit tag 11 (RUN).
    function automatic kind_t classify(input byte_t b);
        kind_t k;
        case (b[7:6])
            TAG_INDEX: k = K_INDEX;
            TAG_DIFF:  k = K_DIFF;
            TAG_LUMA:  k = K_LUMA;
            default:   k = K_RUN;
        endcase
        if (b == OP_RGB)  k = K_RGB;
        if (b == OP_RGBA) k = K_RGBA;
        return k;
    endfunction

    // Index of the last operand byte for ops that carry operands.
    function automatic logic [1:0] last_opnd(input kind_t k);
        logic [1:0] n;
        case (k)
            K_RGB:   n = 2'd2;
            K_RGBA:  n = 2'd3;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic has_opnd(input kind_t k);
        return (k == K_RGB) || (k == K_RGBA) || (k == K_LUMA);
    endfunction

endpackage

// File: rtl/qoi_hash.sv
// QOI colour-cache hash: (r*3 + g*5 + b*7 + a*11) mod 64.
// Ports: px_i pixel in, idx_o 6-bit cache index out.
module qoi_hash
    import qoi_types::*;
(
    input  pixel_t px_i,
    output index_t idx_o
);

    // Mod-256 sum; only the low six bits survive the mod 64.
    byte_t sum;

    always_comb begin
        sum = px_i.r * 8'd3
            + px_i.g * 8'd5
            + px_i.b * 8'd7
            + px_i.a * 8'd11;
    end

    assign idx_o = index_t'(sum);

endmodule

// File: rtl/qoi_dec.sv
// Register-mapped QOI stream decoder: bytes in via reg0 writes, pixels out via reg0 reads.
// Ports: clk, rst (sync, active-high), cs/we/addr/data_i bus in, data_o read mux out.
module qoi_dec
    import qoi_types::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  cs,
    input  logic  we,
    input  addr_t addr,
    input  byte_t data_i,
    output byte_t data_o
);

    state_t     state_q, state_d;
    size_t      tot_q, tot_d;
    size_t      total_q, total_d;
    size_t      count_q, count_d;
    logic [1:0] bidx_q, bidx_d;
    pixel_t     prev_q, prev_d;
    pixel_t     index_q [64];
    pixel_t     index_d [64];
    kind_t      kind_q, kind_d;
    index_t     opb_q, opb_d;
    byte_t      opnd_q [4];
    byte_t      opnd_d [4];
    logic [1:0] cnt_q, cnt_d;
    index_t     run_q, run_d;

    logic   wr_stb, rd_stb, start;
    logic   emit;
    kind_t  kind;
    byte_t  ops [4];
    index_t lb;
    byte_t  dg;
    pixel_t new_px;
    index_t hidx;
    byte_t  status;
    size_t  count_inc;

    assign wr_stb = cs & we & (addr == 3'd0);
    assign rd_stb = cs & ~we & (addr == 3'd0);
    assign start  = cs & we & (addr == 3'd3) & data_i[7];
    assign count_inc = count_q + 30'd1;

    qoi_hash u_hash (
        .px_i  (new_px),
        .idx_o (hidx)
    );

    // Pixel formed in the cycle of the completing write strobe.
    // The final operand comes straight from data_i, not from opnd_q.
    always_comb begin
        kind = (state_q == S_OPCODE) ? classify(data_i) : kind_q;
        ops = opnd_q;
        ops[cnt_q] = data_i;
        lb = (state_q == S_OPCODE) ? data_i[5:0] : opb_q;
        dg = {2'b00, lb} - 8'd32;
        new_px = prev_q;
        case (kind)
            K_RGB: begin
                new_px = '{r: ops[0], g: ops[1],
                           b: ops[2], a: prev_q.a};
            end
            K_RGBA: begin
                new_px = '{r: ops[0], g: ops[1],
                           b: ops[2], a: ops[3]};
            end
            K_INDEX: new_px = index_q[data_i[5:0]];
            K_DIFF: begin
                new_px.r = prev_q.r + {6'b0, data_i[5:4]} - 8'd2;
                new_px.g = prev_q.g + {6'b0, data_i[3:2]} - 8'd2;
                new_px.b = prev_q.b + {6'b0, data_i[1:0]} - 8'd2;
            end
            K_LUMA: begin
                new_px.r = prev_q.r + dg + {4'b0, ops[0][7:4]} - 8'd8;
                new_px.g = prev_q.g + dg;
                new_px.b = prev_q.b + dg + {4'b0, ops[0][3:0]} - 8'd8;
            end
            default: new_px = prev_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tot_d   = tot_q;
        total_d = total_q;
        count_d = count_q;
        bidx_d  = bidx_q;
        prev_d  = prev_q;
        index_d = index_q;
        kind_d  = kind_q;
        opb_d   = opb_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        emit    = 1'b0;

        if (cs && we && addr[2]) begin
            case (addr[1:0])
                2'd0:    tot_d[7:0]   = data_i;
                2'd1:    tot_d[15:8]  = data_i;
                2'd2:    tot_d[23:16] = data_i;
                default: tot_d[29:24] = data_i[5:0];
            endcase
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    total_d = tot_q;
                    count_d = '0;
                    bidx_d  = '0;
                    run_d   = '0;
                    prev_d  = PX_INIT;
                    index_d = '{default: '0};
                    state_d = (tot_q == '0) ? S_DONE : S_OPCODE;
                end
            end
            S_OPCODE: begin
                if (wr_stb) begin
                    kind_d = kind;
                    opb_d  = data_i[5:0];
                    cnt_d  = '0;
                    run_d  = (kind == K_RUN) ? data_i[5:0] : '0;
                    if (has_opnd(kind)) state_d = S_OPERAND;
                    else                emit    = 1'b1;
                end
            end
            S_OPERAND: begin
                if (wr_stb) begin
                    opnd_d[cnt_q] = data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == last_opnd(kind_q)) emit = 1'b1;
                end
            end
            S_EMIT: begin
                if (rd_stb) begin
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        count_d = count_inc;
                        // Truncates a run at the total.
                        if (count_inc == total_q) begin
                            state_d = S_DONE;
                        end else if (run_q != '0) begin
                            run_d = run_q - 6'd1;
                        end else begin
                            state_d = S_OPCODE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            state_d       = S_EMIT;
            bidx_d        = '0;
            prev_d        = new_px;
            index_d[hidx] = new_px;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tot_q   <= '0;
            total_q <= '0;
            count_q <= '0;
            bidx_q  <= '0;
            prev_q  <= PX_INIT;
            index_q <= '{default: '0};
            kind_q  <= K_RGB;
            opb_q   <= '0;
            opnd_q  <= '{default: '0};
            cnt_q   <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            tot_q   <= tot_d;
            total_q <= total_d;
            count_q <= count_d;
            bidx_q  <= bidx_d;
            prev_q  <= prev_d;
            index_q <= index_d;
            kind_q  <= kind_d;
            opb_q   <= opb_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        status = {
            state_q inside {S_OPCODE, S_OPERAND, S_EMIT},
            3'b000,
            bidx_q,
            state_q inside {S_OPCODE, S_OPERAND},
            state_q == S_EMIT
        };
    end

    always_comb begin
        data_o = '0;
        unique case (addr)
            3'd0: begin
                if (state_q == S_EMIT) begin
                    case (bidx_q)
                        2'd0:    data_o = prev_q.r;
                        2'd1:    data_o = prev_q.g;
                        2'd2:    data_o = prev_q.b;
                        default: data_o = prev_q.a;
                    endcase
                end
            end
            3'd3: data_o = status;
            3'd4: data_o = count_q[7:0];
            3'd5: data_o = count_q[15:8];
            3'd6: data_o = count_q[23:16];
            3'd7: data_o = {2'b00, count_q[29:24]};
            default: data_o = '0;
        endcase
    end

endmodule
